// File: rtl/ir_regfile_mp_pkg.sv
// Shared defaults and clear-engine state encoding for the instruction register file.
package ir_regfile_mp_pkg;
    localparam int IR_DATA_W = 16;
    localparam int IR_ADDR_W = 3;
    localparam int IR_NUM_RD = 2;

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_RUN  = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_e;
endpackage

// File: rtl/ir_rf_clr_fsm.sv
// Bulk-clear sequencer: walks every entry index once, then pulses done.
// state    | meaning
// CLR_IDLE | waiting for clr_req
// CLR_RUN  | clearing entry idx, one per cycle
// CLR_DONE | last entry cleared, clr_done high for one cycle
module ir_rf_clr_fsm
    import ir_regfile_mp_pkg::*;
#(
    parameter int ADDR_W = IR_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    clr_state_e        state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                CLR_IDLE: begin
                    if (clr_req) begin
                        state_q <= CLR_RUN;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLR_RUN: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= CLR_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                CLR_DONE: begin
                    state_q <= CLR_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= CLR_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = (state_q == CLR_RUN);
    assign clr_idx  = idx_q;
    assign clr_busy = busy_q;
    assign clr_done = done_q;
endmodule

// File: rtl/ir_regfile_mp.sv
// Instruction register file: one write port, NUM_RD registered read ports,
// per-entry valid bits, occupancy counter and a sequenced bulk clear.
module ir_regfile_mp
    import ir_regfile_mp_pkg::*;
#(
    parameter int DATA_W = IR_DATA_W,
    parameter int ADDR_W = IR_ADDR_W,
    parameter int NUM_RD = IR_NUM_RD,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    output logic                     wr_rdy,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_vld,
    output logic [NUM_RD-1:0]        rd_hit,
    output logic [ADDR_W:0]          occ,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W:0]   occ_q, occ_d;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr_fire;

    ir_rf_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    assign wr_rdy  = ~clr_busy;
    assign wr_fire = wr_en & ~clr_busy;

    // Port writes and clear writes never coincide: wr_rdy is low for the whole clear.
    always_comb begin
        valid_d = valid_q;
        occ_d   = occ_q;
        if (wr_fire) begin
            valid_d[wr_addr] = 1'b1;
            if (!valid_q[wr_addr]) occ_d = occ_q + 1'b1;
        end
        if (clr_we) begin
            valid_d[clr_idx] = 1'b0;
            if (valid_q[clr_idx]) occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we)       mem_q[clr_idx] <= '0;
        else if (wr_fire) mem_q[wr_addr] <= wr_data;
    end

    assign occ = occ_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data_q, data_d;
        logic              hit_q, hit_d, vld_q;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        // An entry being cleared this cycle reads as empty regardless of bypass.
        always_comb begin
            data_d = data_q;
            hit_d  = hit_q;
            if (rd_en[p]) begin
                if (clr_we && clr_idx == addr) begin
                    hit_d  = 1'b0;
                    data_d = '0;
                end else if (BYPASS != 0 && wr_fire && wr_addr == addr) begin
                    hit_d  = 1'b1;
                    data_d = wr_data;
                end else begin
                    hit_d  = valid_q[addr];
                    data_d = valid_q[addr] ? mem_q[addr] : '0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_q <= '0;
                hit_q  <= 1'b0;
                vld_q  <= 1'b0;
            end else begin
                data_q <= data_d;
                hit_q  <= hit_d;
                vld_q  <= rd_en[p];
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data_q;
        assign rd_hit[p] = hit_q;
        assign rd_vld[p] = vld_q;
    end
endmodule

// File: tb/tb_ir_regfile_mp.sv
// Bench for ir_regfile_mp: a BYPASS=0 and a BYPASS=1 instance share one stimulus
// and are compared every cycle against a phase-based behavioural model.
module tb_ir_regfile_mp;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NR = 2;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NR-1:0] rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic clr_req;

    logic [1:0]              wr_rdy;
    logic [1:0][NR*DW-1:0]   rd_data;
    logic [1:0][NR-1:0]      rd_vld;
    logic [1:0][NR-1:0]      rd_hit;
    logic [1:0][AW:0]        occ;
    logic [1:0]              clr_busy;
    logic [1:0]              clr_done;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar b = 0; b < 2; b++) begin : g_dut
        ir_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(b)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en),
            .wr_rdy   (wr_rdy[b]),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_en    (rd_en),
            .rd_addr  (rd_addr),
            .rd_data  (rd_data[b]),
            .rd_vld   (rd_vld[b]),
            .rd_hit   (rd_hit[b]),
            .occ      (occ[b]),
            .clr_req  (clr_req),
            .clr_busy (clr_busy[b]),
            .clr_done (clr_done[b])
        );
    end

    task automatic chk(input string name, input int b, input int p,
                       input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (bypass=%0d port=%0d) t=%0t: got %0h, expected %0h",
                     name, b, p, $time, act, exp);
        end
    endtask

    // Model: m_phase 0 = idle, 1..DEPTH = clearing entry m_phase-1, DEPTH+1 = done.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_val [DEPTH];
    int            m_occ = 0;
    int            m_phase = 0;
    logic [DW-1:0] m_data [2][NR];
    bit            m_hit [2][NR];
    bit            m_vld [NR];
    bit            m_ok = 0;

    always @(posedge clk) begin
        bit fire;
        bit clearing;
        int cidx;
        int a;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
            for (int p = 0; p < NR; p++) begin
                m_vld[p] = 0;
                for (int b = 0; b < 2; b++) begin
                    m_data[b][p] = '0;
                    m_hit[b][p] = 0;
                end
            end
            m_occ = 0;
            m_phase = 0;
            m_ok = 1;
        end else begin
            fire = wr_en && (m_phase == 0);
            clearing = (m_phase >= 1) && (m_phase <= DEPTH);
            cidx = m_phase - 1;
            for (int p = 0; p < NR; p++) begin
                m_vld[p] = rd_en[p];
                if (rd_en[p]) begin
                    a = int'(rd_addr[p*AW +: AW]);
                    for (int b = 0; b < 2; b++) begin
                        if (clearing && cidx == a) begin
                            m_hit[b][p] = 0;
                            m_data[b][p] = '0;
                        end else if (b == 1 && fire && int'(wr_addr) == a) begin
                            m_hit[b][p] = 1;
                            m_data[b][p] = wr_data;
                        end else begin
                            m_hit[b][p] = m_val[a];
                            m_data[b][p] = m_val[a] ? m_mem[a] : '0;
                        end
                    end
                end
            end
            if (fire) begin
                if (!m_val[wr_addr]) m_occ++;
                m_val[wr_addr] = 1;
                m_mem[wr_addr] = wr_data;
            end
            if (clearing) begin
                if (m_val[cidx]) m_occ--;
                m_val[cidx] = 0;
                m_mem[cidx] = '0;
            end
            if (m_phase == 0) m_phase = clr_req ? 1 : 0;
            else if (m_phase == DEPTH + 1) m_phase = 0;
            else m_phase++;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            for (int b = 0; b < 2; b++) begin
                chk("wr_rdy", b, 0, 64'(wr_rdy[b]), 64'(m_phase == 0));
                chk("clr_busy", b, 0, 64'(clr_busy[b]), 64'(m_phase != 0));
                chk("clr_done", b, 0, 64'(clr_done[b]), 64'(m_phase == DEPTH + 1));
                chk("occ", b, 0, 64'(occ[b]), 64'(m_occ));
                for (int p = 0; p < NR; p++) begin
                    chk("rd_vld", b, p, 64'(rd_vld[b][p]), 64'(m_vld[p]));
                    chk("rd_hit", b, p, 64'(rd_hit[b][p]), 64'(m_hit[b][p]));
                    chk("rd_data", b, p, 64'(rd_data[b][p*DW +: DW]), 64'(m_data[b][p]));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = '0;
        clr_req = 1'b0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
    endtask

    initial begin
        int busy_cnt;
        int done_at;
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en = '0;
        rd_addr = '0;
        clr_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_occ", 1, 0, 64'(occ[1]), 64'd0);
        chk("reset_wr_rdy", 1, 0, 64'(wr_rdy[1]), 64'd1);
        rst_n = 1'b1;

        // Write then read back one entry.
        wr(3, 16'hA5A5);
        tick();
        rd_en = 2'b01;
        rd_addr[2:0] = 3'd3;
        tick();
        chk("t1_vld", 1, 0, 64'(rd_vld[1][0]), 64'd1);
        chk("t1_hit", 1, 0, 64'(rd_hit[1][0]), 64'd1);
        chk("t1_data", 1, 0, 64'(rd_data[1][15:0]), 64'hA5A5);
        chk("t1_occ", 1, 0, 64'(occ[1]), 64'd1);

        // Miss on an unwritten entry; rewrite keeps occupancy.
        rd_en = 2'b10;
        rd_addr[5:3] = 3'd5;
        wr(3, 16'h1234);
        tick();
        chk("t2_hit", 1, 1, 64'(rd_hit[1][1]), 64'd0);
        chk("t2_data", 1, 1, 64'(rd_data[1][31:16]), 64'd0);
        chk("t2_occ", 1, 0, 64'(occ[1]), 64'd1);
        rd_en = 2'b01;
        rd_addr[2:0] = 3'd3;
        tick();
        chk("t2_reread", 1, 0, 64'(rd_data[1][15:0]), 64'h1234);

        // Same-cycle write and read: forwarded only with bypass.
        wr(2, 16'hBEEF);
        rd_en = 2'b01;
        rd_addr[2:0] = 3'd2;
        tick();
        chk("t3_byp_data", 1, 0, 64'(rd_data[1][15:0]), 64'hBEEF);
        chk("t3_byp_hit", 1, 0, 64'(rd_hit[1][0]), 64'd1);
        chk("t3_nobyp_data", 0, 0, 64'(rd_data[0][15:0]), 64'd0);
        chk("t3_nobyp_hit", 0, 0, 64'(rd_hit[0][0]), 64'd0);
        chk("t3_occ", 0, 0, 64'(occ[0]), 64'd2);

        // Fill, then clear with a write and a second request injected mid-clear.
        for (int i = 0; i < DEPTH; i++) begin
            wr(i, DW'(16'h1000 + i));
            tick();
        end
        chk("t4_full", 1, 0, 64'(occ[1]), 64'd8);
        clr_req = 1'b1;
        tick();
        busy_cnt = 0;
        done_at = 0;
        for (int k = 1; k <= 20; k++) begin
            if (clr_busy[1]) busy_cnt++;
            if (clr_done[1]) done_at = k;
            if (k == 2) wr(7, 16'hFFFF);
            clr_req = (k == 3);
            if (k == 4) begin
                rd_en = 2'b11;
                rd_addr = {3'd5, 3'd3};
            end
            @(negedge clk);
            wr_en = 1'b0;
            rd_en = '0;
            clr_req = 1'b0;
        end
        chk("t4_busy_cycles", 1, 0, 64'(busy_cnt), 64'd9);
        chk("t4_done_cycle", 1, 0, 64'(done_at), 64'd9);
        chk("t4_occ", 1, 0, 64'(occ[1]), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 2'b11;
            rd_addr = {AW'(DEPTH - 1 - i), AW'(i)};
            tick();
        end
        chk("t5_miss7", 1, 1, 64'(rd_hit[1][1]), 64'd0);

        // Reset in the middle of a clear.
        wr(0, 16'h0001); tick();
        wr(1, 16'h0002); tick();
        wr(2, 16'h0003); tick();
        chk("t6_occ_pre", 1, 0, 64'(occ[1]), 64'd3);
        clr_req = 1'b1;
        tick();
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_busy", 1, 0, 64'(clr_busy[1]), 64'd0);
        chk("t6_occ", 1, 0, 64'(occ[1]), 64'd0);
        chk("t6_wr_rdy", 1, 0, 64'(wr_rdy[1]), 64'd1);
        wr(6, 16'h0066);
        tick();
        rd_en = 2'b01;
        rd_addr[2:0] = 3'd6;
        tick();
        chk("t6_after_occ", 1, 0, 64'(occ[1]), 64'd1);
        chk("t6_after_data", 0, 0, 64'(rd_data[0][15:0]), 64'h0066);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
